// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_pkg: shared definitions for the sequential BCD-to-binary converter.
//   DEFAULT_DIGITS   default number of BCD digits
//   state_t          converter FSM states (IDLE, CONV, DONE)
//   ADJ_THRESH/SUB   reverse double dabble correction: nibble >= 8 -> minus 3
//   nibble_invalid   1 when a 4-bit nibble is not a decimal digit (> 9)
package bcd_pkg;

    localparam int DEFAULT_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    function automatic logic nibble_invalid(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: handshake bundle for the BCD-to-binary converter.
//   in_valid/in_ready/bcd_in      source side (BCD word in)
//   out_valid/out_ready/bin_out   sink side (binary result out)
//   err                           result came from a word with a nibble > 9
//   dbg_state                     converter FSM state, for observation only
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. valid, once raised by the converter, stays up with its data
// stable until that edge; ready may change freely.
// master = side driving the converter (source + sink), slave = converter.
interface bcd_to_bin_seq_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
);
    localparam int N = 4 * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] bcd_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] bin_out;
    logic         err;
    state_t       dbg_state;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err, dbg_state
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err, dbg_state
    );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// bcd_digit_adjust: one reverse-double-dabble correction cell.
//   nib_i  4-bit nibble after the right shift
//   nib_o  nib_i - 3 when nib_i >= 8, else nib_i (4-bit, no borrow out)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= ADJ_THRESH) ? (nib_i - ADJ_SUB) : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to unsigned binary converter using
// reverse double dabble, one shift-and-correct step per clock.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of bcd_to_bin_seq_if (BCD in, binary/err out, state)
// A valid word takes N = 4*DIGITS steps; a word with any nibble > 9 goes
// straight to DONE with err=1 and bin_out=0. One conversion in flight.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
)(
    input  logic                  clk,
    input  logic                  reset,
    bcd_to_bin_seq_if.slave       bus
);

    localparam int N  = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [2*N-1:0]  sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    bin_q, bin_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;

    logic [2*N-1:0]  sr_shift;
    logic [N-1:0]    sr_hi_adj;
    logic [2*N-1:0]  sr_step;
    logic            in_bad;

    // BCD digits live in the upper half; binary bits collect in the lower
    // half as they shift out of the BCD field.
    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_i (sr_shift[N + 4*g +: 4]),
            .nib_o (sr_hi_adj[4*g +: 4])
        );
    end

    assign sr_step = {sr_hi_adj, sr_shift[N-1:0]};

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nibble_invalid(bus.bcd_in[4*i +: 4])) begin
                in_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (in_bad) begin
                        bin_d       = '0;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        sr_d    = {bus.bcd_in, {N{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CW'(1);
                // Final step: result is taken from this step's value directly.
                if (cnt_q == CNT_LAST) begin
                    bin_d       = sr_step[N-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // bin_out/err are kept after the handoff; only valid drops.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.bin_out   = bin_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: self-checking bench for bcd_to_bin_seq.
// Expected results come from a decimal-arithmetic model (digit-by-digit
// val = val*10 + digit). Inputs change and outputs are sampled on negedge.
module tb_bcd_to_bin_seq;
    import bcd_pkg::*;

    localparam int DIGITS = 6;
    localparam int N      = 4 * DIGITS;
    localparam int TMO    = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [N:0] exp_q[$];   // {err, bin}

    bcd_to_bin_seq_if #(.DIGITS(DIGITS)) bus();

    bcd_to_bin_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [N-1:0] w,
                                      output logic [N-1:0] b, output logic e);
        int unsigned val;
        int unsigned nib;
        val = 0;
        e   = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = int'(w[4*d +: 4]);
            if (nib > 9) e = 1'b1;
            val = val * 10 + nib;
        end
        b = e ? '0 : N'(val);
    endfunction

    function automatic logic [N-1:0] rand_bcd();
        logic [N-1:0] w;
        for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
        return w;
    endfunction

    // ---------------- driver tasks (no checking) ----------------
    task automatic wait_in_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge with in_ready=1; returns at the negedge after the
    // accepting edge.
    task automatic send_word(input logic [N-1:0] w, output int acc_cyc);
        bus.bcd_in   = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    // lat = edges after the accepting edge until out_valid is seen
    // (0 means out_valid already high right after the accept edge).
    task automatic wait_out_valid(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Full conversion up to DONE; leaves the result pending.
    task automatic convert(input logic [N-1:0] w, output bit ok, output int lat,
                           output int acc_cyc, output logic rdy_after,
                           output logic [N-1:0] b, output logic e);
        bit ok1, ok2;
        wait_in_ready(ok1);
        send_word(w, acc_cyc);
        rdy_after = bus.in_ready;
        wait_out_valid(lat, ok2);
        ok = ok1 && ok2;
        b  = bus.bin_out;
        e  = bus.err;
    endtask

    task automatic collect();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.bin_out !== '0) begin errors++; $display("FAIL reset_bin_out: got %h expected 0", bus.bin_out); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_known();
        logic [N-1:0] tbl [3];
        logic [N-1:0] eb, b;
        logic ee, e, rdy;
        int lat, acc;
        bit ok;
        tbl[0] = 24'h999999;
        tbl[1] = 24'h123456;
        tbl[2] = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            ref_model(tbl[i], eb, ee);
            convert(tbl[i], ok, lat, acc, rdy, b, e);
            checks++; if (!ok) begin errors++; $display("FAIL known_timeout[%0d]: no handshake within %0d cycles", i, TMO); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL known_in_ready_drop[%0d]: got %b expected 0", i, rdy); end
            checks++; if (lat != N) begin errors++; $display("FAIL known_latency[%0d]: got %0d expected %0d", i, lat, N); end
            checks++; if (b !== eb) begin errors++; $display("FAIL known_bin[%0d]: in %h got %h expected %h", i, tbl[i], b, eb); end
            checks++; if (e !== ee) begin errors++; $display("FAIL known_err[%0d]: got %b expected %b", i, e, ee); end
            collect();
            checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL known_handoff[%0d]: in_ready %b out_valid %b expected 1 0", i, bus.in_ready, bus.out_valid); end
        end
        checks++; if (bus.bin_out !== 24'h000000) begin errors++; $display("FAIL known_zero_kept: got %h expected 000000", bus.bin_out); end
    endtask

    task automatic test_invalid();
        logic [N-1:0] w, eb, b;
        logic ee, e, rdy;
        int lat, acc;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                w = 24'h00000A;
            end else begin
                w = rand_bcd();
                w[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            end
            ref_model(w, eb, ee);
            convert(w, ok, lat, acc, rdy, b, e);
            checks++; if (!ok) begin errors++; $display("FAIL invalid_timeout[%0d]: no handshake within %0d cycles", i, TMO); end
            checks++; if (lat != 0) begin errors++; $display("FAIL invalid_latency[%0d]: got %0d expected 0", i, lat); end
            checks++; if (b !== eb || e !== ee) begin errors++; $display("FAIL invalid_result[%0d]: in %h got bin %h err %b expected %h %b", i, w, b, e, eb, ee); end
            collect();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] eb, b;
        logic ee, e, rdy;
        int lat, acc, bad;
        bit ok;
        ref_model(24'h000042, eb, ee);
        convert(24'h000042, ok, lat, acc, rdy, b, e);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no handshake within %0d cycles", TMO); end
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                bus.bcd_in   = 24'h000001;
                bus.in_valid = 1'b1;
            end
            if (i == 4) bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.bin_out !== eb || bus.err !== ee || bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles expected 0", bad); end
        checks++; if (bus.bin_out !== eb || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_after_hold: bin %h valid %b expected %h 1", bus.bin_out, bus.out_valid, eb); end
        collect();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff: in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.bin_out !== eb) begin errors++; $display("FAIL bp_bin_kept: got %h expected %h", bus.bin_out, eb); end
        ref_model(24'h000001, eb, ee);
        convert(24'h000001, ok, lat, acc, rdy, b, e);
        checks++; if (!ok || lat != N) begin errors++; $display("FAIL bp_next_latency: ok %b got %0d expected %0d", ok, lat, N); end
        checks++; if (b !== eb || e !== ee) begin errors++; $display("FAIL bp_next_result: got %h %b expected %h %b", b, e, eb, ee); end
        collect();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] b;
        logic e, rdy;
        int lat, acc, seen;
        bit ok;
        wait_in_ready(ok);
        send_word(24'h500000, acc);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_hs: in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.bin_out !== '0 || bus.err !== 1'b0) begin errors++; $display("FAIL midreset_data: bin %h err %b expected 0 0", bus.bin_out, bus.err); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_valid: out_valid high %0d cycles expected 0", seen); end
        convert(24'h500000, ok, lat, acc, rdy, b, e);
        checks++; if (!ok || lat != N) begin errors++; $display("FAIL midreset_redo_latency: ok %b got %0d expected %0d", ok, lat, N); end
        checks++; if (b !== 24'h07A120 || e !== 1'b0) begin errors++; $display("FAIL midreset_redo_result: got %h %b expected 07a120 0", b, e); end
        collect();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w, eb, b;
        logic ee, e, rdy;
        logic [N:0] exp;
        int lat, acc, prev_acc;
        bit ok;
        bus.out_ready = 1'b1;
        prev_acc = -1;
        for (int i = 0; i < 12; i++) begin
            w = rand_bcd();
            ref_model(w, eb, ee);
            exp_q.push_back({ee, eb});
            convert(w, ok, lat, acc, rdy, b, e);
            exp = exp_q.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: no handshake within %0d cycles", i, TMO); end
            checks++; if ({e, b} !== exp) begin errors++; $display("FAIL b2b_result[%0d]: in %h got %h %b expected %h %b", i, w, b, e, exp[N-1:0], exp[N]); end
            if (prev_acc >= 0) begin
                checks++; if (acc - prev_acc != N + 2) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, acc - prev_acc, N + 2); end
            end
            prev_acc = acc;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_final_idle: in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_known();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to unsigned-binary converter; the inverse of the team's combinational binary-to-BCD block.
- Uses reverse double dabble: one right-shift-and-correct step per clock.
- Sits between display/keypad-style BCD sources and arithmetic logic.
- Valid/ready handshakes on both sides; one conversion in flight at a time.

Parameters:
- DIGITS, 6, number of BCD digits. Localparam N = 4*DIGITS gives the BCD input width, the binary output width and the step count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a BCD word.
- in_ready  output  1  converter idle and able to accept.
- bcd_in  input  N  packed BCD; digit i occupies bits [4i+3:4i], bits [3:0] are least significant.
- out_valid  output  1  result and err are valid.
- out_ready  input  1  sink accepts the result.
- bin_out  output  N  unsigned binary result.
- err  output  1  at least one input nibble was greater than 9.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state IDLE; in_ready=1; out_valid=0; bin_out=0; err=0.
  - Internal shift register and step counter cleared to 0.
- FSM states: IDLE, CONV, DONE.
- in_ready = (state==IDLE). Input is accepted only in IDLE.
- in_valid seen in CONV or DONE is ignored: no capture and no side effect.
- Accept at edge k (IDLE, in_valid=1):
  - Check every nibble of bcd_in.
  - If any nibble >9: bin_out<=0, err<=1, state<=DONE. out_valid is high after edge k (1-cycle latency).
  - Otherwise: shift register SR (2N bits) <= {bcd_in, N'b0}, cnt<=0, err<=0, state<=CONV.
- CONV, each edge:
  - SR <= SR >> 1, zero fill.
  - Then, for each of the DIGITS nibbles in SR[2N-1:N] after the shift, if the nibble is >=8, subtract 3 (4-bit arithmetic; no borrow across nibbles).
  - cnt increments.
- Completion: the edge that performs the N-th step also loads bin_out <= low N bits of SR after that step and sets state<=DONE, out_valid<=1.
  - Valid input gives out_valid high after edge k+N (N=24 cycles with defaults).
- DONE:
  - bin_out, err and out_valid are held stable until out_ready=1 at an edge.
  - That edge sets out_valid<=0 and state<=IDLE. bin_out and err keep their last value.
  - A new input can be accepted one cycle after the handoff; there is no same-cycle turnaround.
- out_ready while not in DONE: no effect.
- Reset asserted mid-CONV or in DONE: immediate return to reset values; the in-flight result is discarded and out_valid is never pulsed.
- Result range: all-9s input gives 10^DIGITS - 1, which always fits in N bits, so no overflow condition exists.
- No combinational path from any input to any output. in_ready is decoded from the state register only.

Decomposition:
- Package bcd_pkg holds:
  - DIGITS default.
  - State enum {IDLE, CONV, DONE}.
  - Constant ADJ_THRESH=8 and ADJ_SUB=3.
  - Function nibble_invalid (returns 1 if nibble >9).
- Sub-module bcd_digit_adjust: combinational, 4-bit in and 4-bit out, subtracts 3 when the input is >=8. Instantiate DIGITS copies via generate.
- Counter width is $clog2(N+1).

Test Plan:
- bcd_in=24'h999999, in_valid pulsed one cycle → in_ready falls next cycle; out_valid rises exactly 24 cycles after accept; bin_out=24'h0F423F, err=0.
- bcd_in=24'h123456 → bin_out=24'h01E240 after 24 cycles. Then bcd_in=24'h000000 → bin_out=0, err=0.
- bcd_in=24'h00000A → out_valid one cycle after accept; err=1, bin_out=0; no CONV cycles.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid → bin_out and err stable; in_valid with bcd_in=24'h000001 during the hold is ignored. Then out_ready=1 → IDLE next cycle; a new accept gives bin_out=1.
- Assert reset 10 cycles into a conversion of 24'h500000 → outputs at reset values immediately; out_valid stays 0. After release, converting 24'h500000 gives 24'h07A120.
- Back-to-back random valid BCD words with out_ready tied high → each result equals the decimal value of its input and matches the reference model; throughput is one result per 26 cycles.
